// File: rtl/serial_add16.sv
// Nibble-serial adder/subtractor: one 4-bit slice per cycle through a
// four-cell ripple adder, with valid/ready handshakes on both sides.
module serial_add16 #(
    parameter int unsigned NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [4*NIBBLES-1:0] a,
    input  logic [4*NIBBLES-1:0] b,
    input  logic                 cin,
    input  logic                 sub,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [4*NIBBLES-1:0] sum,
    output logic                 cf,
    output logic                 of,
    output logic                 zf
);

    localparam int unsigned W  = 4 * NIBBLES;
    localparam int unsigned IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t         state;
    logic [W-1:0]   a_r;
    logic [W-1:0]   b_r;
    logic           carry;
    logic [IW-1:0]  idx;

    logic [3:0]     na_c;
    logic [3:0]     nb_c;
    logic [3:0]     ns_c;
    logic [4:0]     c_c;
    logic [W-1:0]   sum_next_c;
    logic [IW+1:0]  shift_c;

    // Current nibble through a ripple of four full-adder cells, merged into the sum
    always_comb begin
        shift_c    = {idx, 2'b00};
        na_c       = 4'(a_r >> shift_c);
        nb_c       = 4'(b_r >> shift_c);
        c_c        = '0;
        ns_c       = '0;
        c_c[0]     = carry;
        for (int i = 0; i < 4; i++) begin
            ns_c[i]   = na_c[i] ^ nb_c[i] ^ c_c[i];
            c_c[i+1]  = (na_c[i] & nb_c[i]) | (c_c[i] & (na_c[i] ^ nb_c[i]));
        end
        sum_next_c = (sum & ~(W'(4'hF) << shift_c)) | (W'(ns_c) << shift_c);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            a_r       <= '0;
            b_r       <= '0;
            carry     <= 1'b0;
            idx       <= '0;
            sum       <= '0;
            cf        <= 1'b0;
            of        <= 1'b0;
            zf        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        // Subtraction is a + ~b + 1, so the inversion and the +1 are folded in here
                        a_r      <= a;
                        b_r      <= sub ? ~b : b;
                        carry    <= sub ? 1'b1 : cin;
                        idx      <= '0;
                        in_ready <= 1'b0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    sum   <= sum_next_c;
                    carry <= c_c[4];
                    idx   <= idx + IW'(1);
                    if (idx == IW'(NIBBLES - 1)) begin
                        cf        <= c_c[4];
                        of        <= c_c[3] ^ c_c[4];
                        zf        <= (sum_next_c == '0);
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add16.sv
// Self-checking bench for serial_add16: directed corner cases plus random
// operations scored against an integer-arithmetic model.
module tb_serial_add16;

    localparam int unsigned NIB = 4;
    localparam int unsigned W   = 4 * NIB;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cf;
    logic         of;
    logic         zf;

    int total = 0;
    int bad   = 0;

    serial_add16 #(.NIBBLES(NIB)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid),
        .out_ready(out_ready), .sum(sum), .cf(cf), .of(of), .zf(zf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain integer arithmetic on the operands
    function automatic void model(input logic [15:0] ma, input logic [15:0] mb,
                                  input logic mcin, input logic msub,
                                  output logic [15:0] es, output logic ecf,
                                  output logic eof, output logic ezf);
        int u;
        int sv;
        int sa;
        int sb;
        sa = int'($signed(ma));
        sb = int'($signed(mb));
        if (!msub) begin
            u   = int'(ma) + int'(mb) + int'(mcin);
            sv  = sa + sb + int'(mcin);
            ecf = (u > 65535);
        end else begin
            u   = int'(ma) - int'(mb);
            sv  = sa - sb;
            ecf = (ma >= mb);
        end
        es  = 16'(u);
        eof = (sv > 32767) || (sv < -32768);
        ezf = (es == 16'h0000);
    endfunction

    // One full operation: accept, latency, result, optional backpressure, handoff
    task automatic run_op(input string name, input logic [15:0] oa, input logic [15:0] ob,
                          input logic ocin, input logic osub, input int hold);
        logic [15:0] es;
        logic        ecf, eof, ezf;
        int          lat;
        int          wait_cnt;
        model(oa, ob, ocin, osub, es, ecf, eof, ezf);
        wait_cnt = 0;
        while (!in_ready && wait_cnt < 20) begin
            @(posedge clk); #1; wait_cnt++;
        end
        total++;
        if (in_ready !== 1'b1) begin
            bad++; $display("FAIL %s in_ready timeout: got %b want 1", name, in_ready);
        end
        a = oa; b = ob; cin = ocin; sub = osub; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        // Operands change while the block works; the latched values must win
        a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom); sub = 1'($urandom);
        total++;
        if (in_ready !== 1'b0) begin
            bad++; $display("FAIL %s accept: in_ready got %b want 0", name, in_ready);
        end
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1; lat++;
        end
        total++;
        if (lat != NIB) begin
            bad++; $display("FAIL %s latency: got %0d want %0d", name, lat, NIB);
        end
        total++;
        if (sum !== es || cf !== ecf || of !== eof || zf !== ezf) begin
            bad++;
            $display("FAIL %s result: got sum=%h cf=%b of=%b zf=%b want sum=%h cf=%b of=%b zf=%b",
                     name, sum, cf, of, zf, es, ecf, eof, ezf);
        end
        for (int k = 0; k < hold; k++) begin
            in_valid = 1'b1;
            a = 16'($urandom); b = 16'($urandom);
            @(posedge clk); #1;
            total++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || sum !== es || cf !== ecf ||
                of !== eof || zf !== ezf) begin
                bad++;
                $display("FAIL %s hold%0d: got v=%b r=%b sum=%h cf=%b of=%b zf=%b want v=1 r=0 sum=%h",
                         name, k, out_valid, in_ready, sum, cf, of, zf, es);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL %s handoff: got r=%b v=%b want r=1 v=0", name, in_ready, out_valid);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || sum !== 16'h0 || cf !== 1'b0 ||
            of !== 1'b0 || zf !== 1'b0) begin
            bad++;
            $display("FAIL reset: got r=%b v=%b sum=%h cf=%b of=%b zf=%b want r=1 v=0 sum=0 flags=0",
                     in_ready, out_valid, sum, cf, of, zf);
        end
        #2 rst_n = 1'b1;
    endtask

    task automatic test_directed();
        run_op("add_basic", 16'h1234, 16'h4321, 1'b0, 1'b0, 0);
        run_op("wrap",      16'hFFFF, 16'h0001, 1'b0, 1'b0, 0);
        run_op("ovf_pos",   16'h7FFF, 16'h0001, 1'b0, 1'b0, 0);
        run_op("sub_neg",   16'h0005, 16'h0007, 1'b0, 1'b1, 0);
        run_op("sub_cin",   16'h0007, 16'h0005, 1'b1, 1'b1, 0);
        run_op("add_cin",   16'h000F, 16'h0000, 1'b1, 1'b0, 0);
        run_op("sub_ovf",   16'h8000, 16'h0001, 1'b0, 1'b1, 0);
        run_op("sub_zero",  16'hABCD, 16'hABCD, 1'b0, 1'b1, 0);
    endtask

    task automatic test_backpressure();
        run_op("backpress", 16'h0F0F, 16'hF0F1, 1'b0, 1'b0, 5);
    endtask

    task automatic test_random();
        for (int n = 0; n < 40; n++)
            run_op("random", 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom),
                   int'($urandom_range(0, 2)));
    endtask

    task automatic test_back_to_back();
        for (int n = 0; n < 4; n++)
            run_op("b2b", 16'($urandom), 16'($urandom), 1'b0, 1'($urandom), 0);
    endtask

    task automatic test_reset_midrun();
        a = 16'hFFFF; b = 16'hFFFF; cin = 1'b1; sub = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || sum !== 16'h0 || cf !== 1'b0 ||
            of !== 1'b0 || zf !== 1'b0) begin
            bad++;
            $display("FAIL midrun_reset: got r=%b v=%b sum=%h cf=%b of=%b zf=%b want r=1 v=0 sum=0 flags=0",
                     in_ready, out_valid, sum, cf, of, zf);
        end
        @(posedge clk);
        #2 rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            total++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                bad++;
                $display("FAIL post_reset_idle: got v=%b r=%b want v=0 r=1", out_valid, in_ready);
            end
        end
        run_op("after_reset", 16'h0001, 16'h0001, 1'b0, 1'b0, 0);
    endtask

    task automatic test_first_accept();
        rst_n = 1'b0;
        #3;
        a = 16'h0002; b = 16'h0003; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        total++;
        if (in_ready !== 1'b0) begin
            bad++; $display("FAIL first_accept: in_ready got %b want 0", in_ready);
        end
        repeat (NIB) @(posedge clk);
        #1;
        total++;
        if (out_valid !== 1'b1 || sum !== 16'h0005) begin
            bad++;
            $display("FAIL first_accept result: got v=%b sum=%h want v=1 sum=0005", out_valid, sum);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_random();
        test_back_to_back();
        test_reset_midrun();
        test_first_accept();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
